// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer, flush and freeze.
// Optional STALL_CNT_EN adds a saturating stall counter output (stall_cnt).
module mem_wb_skid_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_read_value,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_mem_read_value,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_wb_value
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high
    // (and neither rst nor flush nor freeze is active); valid never waits on ready.

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_read_value;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] wb_value;
    } entry_t;

    state_t state, state_n;
    entry_t main_q, main_n;
    entry_t skid_q, skid_n;
    entry_t in_entry;
    logic   accept;
    logic   pop;

    // Write-back value is resolved once, at capture, so the WB stage sees a plain register.
    always_comb begin
        in_entry                = '0;
        in_entry.wb_en          = in_wb_en;
        in_entry.mem_r_en       = in_mem_r_en;
        in_entry.alu_result     = in_alu_result;
        in_entry.mem_read_value = in_mem_read_value;
        in_entry.dest           = in_dest;
        in_entry.wb_value       = in_mem_r_en ? in_mem_read_value : in_alu_result;
    end

    assign in_ready  = !freeze && (state != FULL);
    assign out_valid = !freeze && (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
            main_n  = '0;
            skid_n  = '0;
        end else if (!freeze) begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n = ONE;
                        main_n  = in_entry;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_n = in_entry;
                    end else if (accept) begin
                        state_n = FULL;
                        skid_n  = in_entry;
                    end else if (pop) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_n = ONE;
                        main_n  = skid_q;
                    end
                end
                default: begin
                    state_n = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_n;
            main_q <= main_n;
            skid_q <= skid_n;
        end
    end

    // A bubble must never write the register file; the rest of the payload simply holds.
    assign out_wb_en          = out_valid && main_q.wb_en;
    assign out_mem_r_en       = main_q.mem_r_en;
    assign out_alu_result     = main_q.alu_result;
    assign out_mem_read_value = main_q.mem_read_value;
    assign out_dest           = main_q.dest;
    assign out_wb_value       = main_q.wb_value;

`ifdef STALL_CNT_EN
    logic stall_cond;

    // Counts cycles where a held entry cannot leave; flush deliberately does not clear it.
    assign stall_cond = (out_valid && !out_ready) || (freeze && (state != EMPTY));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_cond && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule
